// File: rtl/f_reg_file_pkg.sv
// ----------------------------------------------------------------------------
// f_reg_file_pkg
//   Shared constants and types for the multi-port FP register file.
//   Default geometry: 32 x 32-bit registers, 3 read ports, up to 4
//   outstanding long-latency writes.
//   The build macro F_REG_FILE_BYPASS_EN is consumed by f_reg_file_mp,
//   not by this package.
// ----------------------------------------------------------------------------
package f_reg_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 3;
  localparam int DEF_MAX_PEND = 4;

  typedef logic [DEF_ADDR_W-1:0] freg_addr_t;
  typedef logic [DEF_DATA_W-1:0] freg_data_t;

  // Width of the outstanding-op counter able to hold 0..max_pend.
  function automatic int pend_cnt_w(input int max_pend);
    return $clog2(max_pend + 1);
  endfunction

endpackage

// File: rtl/f_scoreboard.sv
// ----------------------------------------------------------------------------
// f_scoreboard
//   Busy tracking for long-latency (div/sqrt) destinations.
//   Ports:
//     CLK, RESET        clock, synchronous active-high reset
//     issue_en/addr     long-latency dispatch request
//     issue_accept      combinational grant (pre-edge busy / count)
//     wr1_en/addr       long-latency writeback, clears busy
//     pend_cnt          number of outstanding long-latency ops
//     err_wr1           sticky: WR1 hit a register that was not busy
//     busy_nxt          busy vector after this edge's update (for RD_BUSY)
// ----------------------------------------------------------------------------
module f_scoreboard
  import f_reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_PEND = DEF_MAX_PEND,
  localparam int NUM_REGS = 2**ADDR_W,
  localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                issue_accept,
  input  logic                wr1_en,
  input  logic [ADDR_W-1:0]   wr1_addr,
  output logic [CNT_W-1:0]    pend_cnt,
  output logic                err_wr1,
  output logic [NUM_REGS-1:0] busy_nxt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;
  logic                err_wr1_q, err_wr1_d;
  logic                wr1_clr;

  // Grant looks only at pre-edge state: a WR1 freeing the same register or
  // a counter slot this cycle does not help until the next cycle.
  assign issue_accept = issue_en & ~busy_q[issue_addr] & (pend_cnt_q < MAX_CNT) & ~RESET;
  assign wr1_clr      = wr1_en & busy_q[wr1_addr];

  always_comb begin
    busy_d     = busy_q;
    pend_cnt_d = pend_cnt_q;
    err_wr1_d  = err_wr1_q | (wr1_en & ~busy_q[wr1_addr]);
    // Accept needs the target idle and clear needs it busy, so the two
    // updates never touch the same bit.
    if (wr1_clr)      busy_d[wr1_addr]   = 1'b0;
    if (issue_accept) busy_d[issue_addr] = 1'b1;
    case ({issue_accept, wr1_clr})
      2'b10:   pend_cnt_d = pend_cnt_q + ONE;
      2'b01:   pend_cnt_d = pend_cnt_q - ONE;
      default: pend_cnt_d = pend_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
      err_wr1_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      err_wr1_q  <= err_wr1_d;
    end
  end

  assign pend_cnt = pend_cnt_q;
  assign err_wr1  = err_wr1_q;
  assign busy_nxt = busy_d;

endmodule

// File: rtl/f_reg_file_mp.sv
// ----------------------------------------------------------------------------
// f_reg_file_mp
//   Multi-port FP register file: NUM_RD registered read ports, a pipeline
//   writeback port (WR0) and a long-latency writeback port (WR1), plus a
//   busy scoreboard gating long-latency issue.
//   Ports:
//     CLK, RESET             clock, synchronous active-high reset
//     WR0_EN/ADDR/DATA       single-cycle writeback (wins on collision)
//     WR1_EN/ADDR/DATA       long-latency writeback, clears busy
//     RD_ADDR                packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//     RD_DATA / RD_BUSY      registered read data / busy per port (1 cycle)
//     ISSUE_EN/ADDR          long-latency dispatch request
//     ISSUE_ACCEPT           combinational grant
//     PEND_CNT               outstanding long-latency ops
//     ERR_WR1                sticky: WR1 to a non-busy register
//   Build option: F_REG_FILE_BYPASS_EN -- reads see same-edge writes.
// ----------------------------------------------------------------------------
module f_reg_file_mp
  import f_reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int MAX_PEND = DEF_MAX_PEND,
  localparam int NUM_REGS = 2**ADDR_W,
  localparam int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WR0_EN,
  input  logic [ADDR_W-1:0]        WR0_ADDR,
  input  logic [DATA_W-1:0]        WR0_DATA,
  input  logic                     WR1_EN,
  input  logic [ADDR_W-1:0]        WR1_ADDR,
  input  logic [DATA_W-1:0]        WR1_DATA,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  output logic [NUM_RD-1:0]        RD_BUSY,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_ADDR,
  output logic                     ISSUE_ACCEPT,
  output logic [CNT_W-1:0]         PEND_CNT,
  output logic                     ERR_WR1
);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]               rd_busy_q, rd_busy_d;
  logic [NUM_REGS-1:0]             busy_nxt;

  f_scoreboard #(
    .ADDR_W   (ADDR_W),
    .MAX_PEND (MAX_PEND)
  ) u_sb (
    .CLK          (CLK),
    .RESET        (RESET),
    .issue_en     (ISSUE_EN),
    .issue_addr   (ISSUE_ADDR),
    .issue_accept (ISSUE_ACCEPT),
    .wr1_en       (WR1_EN),
    .wr1_addr     (WR1_ADDR),
    .pend_cnt     (PEND_CNT),
    .err_wr1      (ERR_WR1),
    .busy_nxt     (busy_nxt)
  );

  // Storage next state; WR0 applied last so the younger op wins a collision.
  always_comb begin
    mem_d = mem_q;
    if (WR1_EN) mem_d[WR1_ADDR] = WR1_DATA;
    if (WR0_EN) mem_d[WR0_ADDR] = WR0_DATA;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = RD_ADDR[k*ADDR_W +: ADDR_W];
`ifdef F_REG_FILE_BYPASS_EN
    // mem_d already merges both write ports with WR0 priority, so indexing
    // it is exactly the per-port compare/forward mux.
    assign rd_data_d[k] = mem_d[ra];
`else
    assign rd_data_d[k] = mem_q[ra];
`endif
    assign rd_busy_d[k] = busy_nxt[ra];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_q     <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign RD_DATA = rd_data_q;
  assign RD_BUSY = rd_busy_q;

endmodule

// File: doc/f_reg_file_mp.md
Name: f_reg_file_mp

Overview:
Parametrised multi-port floating-point register file with an integrated write scoreboard.
- Serves FPU issue/execute: up to 3 synchronous read ports (rs1/rs2/rs3 for fused multiply-add) and two write ports.
- Write port 0 is the single-cycle pipeline writeback; write port 1 is long-latency writeback (div/sqrt).
- A per-register busy scoreboard with an outstanding-operation counter gates issue of long-latency ops.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth NUM_REGS = 2**ADDR_W.
- NUM_RD, 3, number of read ports (legal range 1..4).
- MAX_PEND, 4, maximum simultaneously outstanding long-latency writes (1..NUM_REGS).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- WR0_EN  in  1  pipeline writeback enable.
- WR0_ADDR  in  ADDR_W  pipeline writeback address.
- WR0_DATA  in  DATA_W  pipeline writeback data.
- WR1_EN  in  1  long-latency writeback enable; also clears busy.
- WR1_ADDR  in  ADDR_W  long-latency writeback address.
- WR1_DATA  in  DATA_W  long-latency writeback data.
- RD_ADDR  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- RD_DATA  out  NUM_RD*DATA_W  packed registered read data.
- RD_BUSY  out  NUM_RD  registered busy flag per read port.
- ISSUE_EN  in  1  request to mark ISSUE_ADDR busy (long-latency op dispatched).
- ISSUE_ADDR  in  ADDR_W  destination register of the issuing op.
- ISSUE_ACCEPT  out  1  combinational grant of the issue request.
- PEND_CNT  out  $clog2(MAX_PEND+1)  number of outstanding long-latency ops.
- ERR_WR1  out  1  sticky error flag.

Behaviour:
- Reset (posedge with RESET=1): all registers 0, all busy bits 0, RD_DATA 0, RD_BUSY 0, PEND_CNT 0, ERR_WR1 0. Reset overrides every write and issue in that cycle, including mid-operation.
- Read latency is 1 cycle. RD_DATA[k] after edge n = register[RD_ADDR[k] sampled at edge n].
- Bypass: if a write to the same address occurs at edge n, that write's data is returned (see Optional Feature).
- Write collision: WR0 and WR1 enabled to the same address on the same edge → WR0 data stored (younger op wins). Busy is still cleared and the counter still decremented by WR1.
- ISSUE_ACCEPT = ISSUE_EN & ~busy[ISSUE_ADDR] & (PEND_CNT < MAX_PEND) & ~RESET. The busy state used is the pre-edge value.
  - A WR1 clearing the same address in the same cycle does not enable the grant; the issue is accepted the following cycle.
- On an accepted issue, busy[ISSUE_ADDR] is set at the edge.
- On WR1_EN with busy[WR1_ADDR]=1, the busy bit is cleared at the edge.
- PEND_CNT update per edge:
  - +1 on an accepted issue.
  - −1 on WR1_EN to a busy register.
  - Both events in the same cycle → unchanged (different addresses guaranteed by the grant rule).
  - Never wraps; saturation is prevented by the grant rule.
- WR1_EN to a non-busy register: data is written, PEND_CNT unchanged, ERR_WR1 set. ERR_WR1 is cleared only by RESET.
- WR0 to a busy register: data is written and busy is unchanged (pipeline hazard avoidance is the issue logic's responsibility).
- RD_BUSY[k] after edge n = busy[RD_ADDR[k]] after the edge-n busy update. An issue at edge n therefore reads busy; a WR1 clear at edge n reads not busy.
- No reads-during-reset hazards: RD_DATA is forced to 0 on the reset edge.

Optional Feature:
- Macro F_REG_FILE_BYPASS_EN.
- Defined: a read at edge n of an address written at edge n returns the new data. If both write ports hit that address, WR0 data is returned, matching the storage rule.
- Undefined: reads return pre-edge contents (old data); the write is visible from edge n+1. Removes the comparator/mux per read port.

Decomposition:
- Package f_reg_file_pkg: default DATA_W/ADDR_W/NUM_RD/MAX_PEND constants, typedef freg_addr_t, typedef freg_data_t.
- Sub-module f_scoreboard (ADDR_W, MAX_PEND):
  - Contains the busy vector, PEND_CNT, ISSUE_ACCEPT and ERR_WR1 logic.
  - Exports the post-update busy vector for RD_BUSY lookup.
- The storage array and the read/bypass logic remain in f_reg_file_mp.

Test Plan:
- Reset then read all 32 regs on 3 ports → RD_DATA 0, RD_BUSY 0, PEND_CNT 0.
- WR0 f5=0x3F800000 at edge n, RD_ADDR0=5 at edge n → with BYPASS_EN 0x3F800000 at n+1; without, 0x00000000 at n+1 and 0x3F800000 at n+2.
- Same edge WR0 f7=0x40000000 and WR1 f7=0x40400000 (f7 busy) → f7 reads 0x40000000, busy[7] cleared, PEND_CNT 1→0.
- Issue f1..f4 on consecutive cycles (MAX_PEND=4), then issue f9 → ISSUE_ACCEPT 0, PEND_CNT 4. WR1 f2 → PEND_CNT 3; reissue f9 next cycle → accepted, PEND_CNT 4.
- Issue f3 while WR1 clears f3 in the same cycle → ISSUE_ACCEPT 0, busy[3]=0 after edge; retry → accepted, RD_BUSY for f3 =1.
- WR1 f10 with busy[10]=0 → f10 written, ERR_WR1=1 sticky, PEND_CNT unchanged. RESET asserted with 2 pending → PEND_CNT 0, ERR_WR1 0, all busy 0.
